ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter TIMEOUT, default 8'd64: cycles allowed in WAIT before a fetch fault is raised.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: value driven on inst at reset and on every fault.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  input  32  fetch address from the core PC stage.
REQ-006 pc_valid  input  1  core presents pc for fetch.
REQ-007 pc_ready  output  1  ifu accepts pc this cycle.
REQ-008 flush  input  1  discard in-flight or held fetch.
REQ-009 imem_req_valid  output  1  request to instruction memory.
REQ-010 imem_req_addr  output  32  word address of the request.
REQ-011 imem_req_ready  input  1  memory accepts request.
REQ-012 imem_resp_valid  input  1  memory returns data, one-cycle pulse, no backpressure.
REQ-013 imem_resp_data  input  32  returned instruction word.
REQ-014 imem_resp_err  input  1  bus error, qualified by imem_resp_valid.
REQ-015 inst  output  32  fetched instruction to the core decoder.
REQ-016 inst_pc  output  32  address inst was fetched from.
REQ-017 inst_valid  output  1  inst/inst_pc/fetch_fault valid.
REQ-018 inst_ready  input  1  core consumes inst.
REQ-019 fetch_fault  output  1  misaligned pc, bus error or timeout; qualified by inst_valid.

Function
REQ-020 FSM states IDLE, REQ, WAIT, HOLD; exactly one active.
REQ-021 IDLE: pc_ready=1 iff stale_pending=0; handshake = pc_valid && pc_ready && !flush.
REQ-022 IDLE handshake with pc[1:0]!=0 -> HOLD next cycle, inst=NOP_INST, fetch_fault=1, inst_pc=pc; no memory request.
REQ-023 IDLE handshake with aligned pc -> latch pc into addr register, REQ next cycle.
REQ-024 REQ: imem_req_valid=1, imem_req_addr=latched addr, both held stable until imem_req_ready; then WAIT next cycle.
REQ-025 imem_req_valid SHALL never be withdrawn before imem_req_ready, including on flush.
REQ-026 WAIT: 8-bit counter cleared on entry, increments each cycle, saturates at TIMEOUT.
REQ-027 WAIT with imem_resp_valid, err=0 -> HOLD, inst=resp_data, fetch_fault=0; err=1 -> HOLD, inst=NOP_INST, fetch_fault=1.
REQ-028 WAIT with counter==TIMEOUT and no response -> HOLD with fault, inst=NOP_INST, stale_pending set.
REQ-029 HOLD: inst_valid=1, outputs stable; inst_ready -> IDLE next cycle; minimum fetch latency pc handshake to inst_valid is 3 cycles (REQ, WAIT, HOLD) with zero-wait memory.
REQ-030 flush in REQ sets drop; REQ->WAIT proceeds; response with drop set is discarded, -> IDLE, drop cleared.
REQ-031 flush in WAIT sets drop; same discard rule; flush coincident with resp_valid discards that response -> IDLE.
REQ-032 flush in HOLD -> IDLE next cycle, inst_valid=0, overrides inst_ready; flush in IDLE blocks that cycle's handshake only.
REQ-033 imem_resp_valid while stale_pending=1 is ignored and clears stale_pending; imem_resp_valid in IDLE/REQ/HOLD otherwise ignored.

Reset
REQ-034 rst SHALL force state IDLE, inst=NOP_INST, inst_pc=32'h8000_0000, inst_valid=0, fetch_fault=0, imem_req_valid=0, imem_req_addr=0, counter=0, drop=0, stale_pending=0.
REQ-035 rst mid-transaction (REQ or WAIT) SHALL abandon it without a stale_pending record; memory is reset by the same rst.

Structure
REQ-036 FSM state encoding, NOP_INST value and reset address SHALL live in the shared defines file next to RESET_VECTOR and RegBus.
REQ-037 Timeout counter SHALL be a sub-module fetch_timer (clear, enable, saturate, done output).
REQ-038 All outputs SHALL be registered except pc_ready and imem_req_valid, which decode from state only.

Verification
REQ-039 pc=0x8000_0000, memory ready immediately, resp 0x00100093 one cycle after accept -> inst_valid with inst=0x00100093, inst_pc=0x8000_0000, fault=0, 3 cycles after handshake.
REQ-040 pc=0x8000_0002 -> no imem_req_valid; next cycle inst_valid, inst=0x00000013, fetch_fault=1.
REQ-041 imem_req_ready held low 5 cycles -> imem_req_valid and addr stable all 5 cycles; flush asserted in cycle 2 -> response dropped, return to IDLE, inst_valid never asserts.
REQ-042 No response for 64 cycles -> fault with NOP_INST; pc_ready stays 0 until late resp arrives at cycle 70, then pc_ready=1 next cycle.
REQ-043 inst_ready low 4 cycles in HOLD -> inst/inst_pc stable; rst asserted in WAIT -> all outputs at REQ-034 values next cycle.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared defines for the instruction fetch unit.
//   RegBus           : datapath / address width
//   RESET_VECTOR     : first fetch address of the core
//   INST_PC_RESET    : value of inst_pc while no fetch has completed
//   NOP_INST_DEFAULT : instruction substituted on reset and on any fault
//   TIMEOUT_DEFAULT  : WAIT cycles tolerated before a fetch fault
//   fetch_state_t    : fetch FSM state encoding
// ----------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam int RegBus = 32;

    localparam logic [RegBus-1:0] RESET_VECTOR     = 32'h8000_0000;
    localparam logic [RegBus-1:0] INST_PC_RESET    = RESET_VECTOR;
    localparam logic [RegBus-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [7:0]        TIMEOUT_DEFAULT  = 8'd64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_timer.sv
// ----------------------------------------------------------------------------
// fetch_timer
// Saturating 8-bit cycle counter used to bound the WAIT state.
//   clk    : clock
//   rst    : synchronous active-high reset
//   clear  : force count to zero (held while not waiting)
//   enable : count one cycle
//   done   : count has reached TIMEOUT (stays high while saturated)
// ----------------------------------------------------------------------------
module fetch_timer
    import ifu_fetch_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [7:0] count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != TIMEOUT)) begin
            count <= count + 8'd1;
        end
    end

    assign done = (count == TIMEOUT);

endmodule

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Single-outstanding instruction fetch unit between the core PC stage and
// instruction memory. FSM: IDLE -> REQ -> WAIT -> HOLD -> IDLE.
//   clk, rst                         : clock, synchronous active-high reset
//   pc, pc_valid, pc_ready           : fetch address handshake from the core
//   flush                            : discard in-flight or held fetch
//   imem_req_valid/addr/ready        : request channel to instruction memory
//   imem_resp_valid/data/err         : response pulse from memory
//   inst, inst_pc, inst_valid,
//   fetch_fault, inst_ready          : result handshake to the decoder
// Faults (misaligned pc, bus error, timeout) deliver NOP_INST with
// fetch_fault set. A timed-out request leaves stale_pending set so the late
// response is swallowed before a new fetch is accepted.
// ----------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [7:0]        TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [RegBus-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RegBus-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req_valid,
    output logic [RegBus-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [RegBus-1:0] imem_resp_data,
    input  logic              imem_resp_err,
    output logic [RegBus-1:0] inst,
    output logic [RegBus-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_fault
);

    fetch_state_t state;
    logic         drop;
    logic         stale_pending;
    logic         timer_done;
    logic         discard;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .done   (timer_done)
    );

    // Only these two outputs are decoded; everything else is registered.
    assign pc_ready       = (state == ST_IDLE) && !stale_pending;
    assign imem_req_valid = (state == ST_REQ);

    // A flush arriving in the same cycle as the response counts as a drop.
    assign discard = drop || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            inst          <= NOP_INST;
            inst_pc       <= INST_PC_RESET;
            inst_valid    <= 1'b0;
            fetch_fault   <= 1'b0;
            imem_req_addr <= '0;
            drop          <= 1'b0;
            stale_pending <= 1'b0;
        end else begin
            // A late response to a timed-out request is consumed here.
            if (imem_resp_valid && stale_pending) begin
                stale_pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pc_valid && pc_ready && !flush) begin
                        if (pc[1:0] != 2'b00) begin
                            state       <= ST_HOLD;
                            inst        <= NOP_INST;
                            inst_pc     <= pc;
                            fetch_fault <= 1'b1;
                            inst_valid  <= 1'b1;
                        end else begin
                            imem_req_addr <= pc;
                            state         <= ST_REQ;
                        end
                    end
                end

                // The request is never withdrawn; a flush only marks it dropped.
                ST_REQ: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (discard) begin
                            state <= ST_IDLE;
                            drop  <= 1'b0;
                        end else begin
                            state       <= ST_HOLD;
                            inst        <= imem_resp_err ? NOP_INST : imem_resp_data;
                            fetch_fault <= imem_resp_err;
                            inst_pc     <= imem_req_addr;
                            inst_valid  <= 1'b1;
                        end
                    end else if (timer_done) begin
                        stale_pending <= 1'b1;
                        if (discard) begin
                            state <= ST_IDLE;
                            drop  <= 1'b0;
                        end else begin
                            state       <= ST_HOLD;
                            inst        <= NOP_INST;
                            fetch_fault <= 1'b1;
                            inst_pc     <= imem_req_addr;
                            inst_valid  <= 1'b1;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (flush || inst_ready) begin
                        state      <= ST_IDLE;
                        inst_valid <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
